ans_stream_encoder: RTL

Parametrised rANS encoder that replaces the fixed-width single-word encoder in the compression datapath. It accepts one symbol per valid/ready handshake with its frequency, cumulative frequency and the stream total, and renormalises by emitting as many `SYM_WIDTH`-bit words as the state needs. It updates the state with a sequential divider instead of a combinational divide/modulo. An explicit flush handshake terminates a stream by emitting the full state with an end marker, so `ena` is no longer used for flushing.

---
 rtl/ans_stream_encoder_pkg.sv | 25 ++
 rtl/ans_stream_encoder_if.sv | 31 +++
 rtl/ans_seq_divider.sv | 61 ++++++
 rtl/ans_stream_encoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ans_stream_encoder_pkg.sv
// Shared types and width helpers for the rANS stream encoder.
package ans_stream_encoder_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_READY  = 3'd1,
        ST_RENORM = 3'd2,
        ST_DIV    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FLUSH  = 3'd5
    } enc_state_e;

    function automatic int tot_width(input int sym_w, input int cnt_w);
        return sym_w + cnt_w;
    endfunction

    function automatic int nwords(input int state_w, input int sym_w);
        return state_w / sym_w;
    endfunction

    // Values for the default 8/8/32 configuration.
    localparam int TOT_WIDTH = tot_width(8, 8);
    localparam int NWORDS    = nwords(32, 8);

endpackage

// File: rtl/ans_stream_encoder_if.sv
// Symbol-in / word-out handshake bundle of the rANS stream encoder.
interface ans_stream_encoder_if
    import ans_stream_encoder_pkg::*;
#(
    parameter int SYM_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    localparam int TOT_W = tot_width(SYM_WIDTH, CNT_WIDTH);

    logic [CNT_WIDTH-1:0] s_count;
    logic [TOT_W-1:0]     s_cumulative;
    logic [TOT_W-1:0]     total_count;
    logic                 in_vld;
    logic                 in_rdy;
    logic                 flush;
    logic [SYM_WIDTH-1:0] out;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 out_last;

    modport master (
        output s_count, s_cumulative, total_count, in_vld, flush, out_rdy,
        input  in_rdy, out, out_vld, out_last
    );

    modport slave (
        input  s_count, s_cumulative, total_count, in_vld, flush, out_rdy,
        output in_rdy, out, out_vld, out_last
    );

endinterface

// File: rtl/ans_seq_divider.sv
// Radix-2 restoring divider, one quotient bit per enabled cycle.
module ans_seq_divider #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder
);
    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    logic [CW-1:0]             cnt_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVISOR_WIDTH-1:0]  div_q;
    logic [DIVISOR_WIDTH:0]    rem_shift;
    logic [DIVISOR_WIDTH:0]    rem_diff;
    logic                      rem_ge;

    // The partial remainder is always below the divisor, so the MSB of the
    // difference is a clean borrow flag.
    always_comb begin
        rem_shift = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, div_q};
        rem_ge    = !rem_diff[DIVISOR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (ena) begin
            if (start) begin
                cnt_q <= CW'(DIVIDEND_WIDTH);
                quo_q <= dividend;
                rem_q <= '0;
                div_q <= divisor;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
                quo_q <= {quo_q[DIVIDEND_WIDTH-2:0], rem_ge};
                rem_q <= rem_ge ? rem_diff[DIVISOR_WIDTH-1:0] : rem_shift[DIVISOR_WIDTH-1:0];
            end
        end
    end

    // done flags the cycle whose closing edge retires the last quotient bit.
    assign busy      = (cnt_q != '0);
    assign done      = (cnt_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ans_stream_encoder.sv
// rANS encoder: renormalises into SYM_WIDTH-bit words, divides sequentially,
// and terminates a stream with an explicit flush of the whole state.
//
// state  | meaning
// INIT   | load x and M from total_count
// READY  | accept a symbol or a flush request
// RENORM | emit low words of x until x < f << b
// DIV    | sequential x / f in progress
// UPDATE | x = q*M + c + r
// FLUSH  | emit every word of x, LSB first, last one marked
module ans_stream_encoder
    import ans_stream_encoder_pkg::*;
#(
    parameter int SYM_WIDTH   = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int STATE_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    output logic                  err,
    ans_stream_encoder_if.slave   bus
);
    localparam int TOT_W   = tot_width(SYM_WIDTH, CNT_WIDTH);
    localparam int N_WORDS = nwords(STATE_WIDTH, SYM_WIDTH);
    localparam int WC_W    = $clog2(N_WORDS + 1);

    if ((STATE_WIDTH < 2 * SYM_WIDTH + CNT_WIDTH) || (STATE_WIDTH % SYM_WIDTH != 0)) begin : g_bad_width
        $error("STATE_WIDTH must be >= 2*SYM_WIDTH+CNT_WIDTH and a multiple of SYM_WIDTH");
    end

    enc_state_e               state_q, state_d;
    logic [STATE_WIDTH-1:0]   x_q, x_d;
    logic [TOT_W-1:0]         m_q, m_d;
    logic [TOT_W-1:0]         c_q, c_d;
    logic [CNT_WIDTH-1:0]     f_q, f_d;
    logic [WC_W-1:0]          wc_q, wc_d;
    logic [SYM_WIDTH-1:0]     out_q, out_d;
    logic                     ov_q, ov_d;
    logic                     ol_q, ol_d;
    logic                     err_q, err_d;

    logic                     div_start;
    logic                     div_busy;
    logic                     div_done;
    logic [STATE_WIDTH-1:0]   div_quo;
    logic [CNT_WIDTH-1:0]     div_rem;

    logic [STATE_WIDTH-1:0]   thresh;
    logic                     need_word;
    logic                     out_hs;
    logic [TOT_W:0]           c_plus_f;
    logic                     sym_illegal;

    ans_seq_divider #(
        .DIVIDEND_WIDTH (STATE_WIDTH),
        .DIVISOR_WIDTH  (CNT_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (div_start),
        .dividend  (x_q),
        .divisor   (f_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        thresh      = STATE_WIDTH'({f_q, {SYM_WIDTH{1'b0}}});
        need_word   = (x_q >= thresh);
        out_hs      = ov_q && bus.out_rdy;
        c_plus_f    = {1'b0, bus.s_cumulative} + (TOT_W + 1)'(bus.s_count);
        sym_illegal = (bus.s_count == '0) || (c_plus_f > {1'b0, m_q});
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        m_d       = m_q;
        c_d       = c_q;
        f_d       = f_q;
        wc_d      = wc_q;
        out_d     = out_q;
        ov_d      = ov_q;
        ol_d      = ol_q;
        err_d     = err_q;
        div_start = 1'b0;

        case (state_q)
            ST_INIT: begin
                x_d     = STATE_WIDTH'(bus.total_count);
                m_d     = bus.total_count;
                state_d = ST_READY;
            end
            ST_READY: begin
                if (bus.flush) begin
                    wc_d    = WC_W'(N_WORDS);
                    state_d = ST_FLUSH;
                end else if (bus.in_vld) begin
                    f_d = bus.s_count;
                    c_d = bus.s_cumulative;
                    if (sym_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RENORM;
                    end
                end
            end
            ST_RENORM: begin
                // The threshold is re-evaluated after every word, so a symbol
                // that needs no renormalisation goes straight to the divider.
                if (ov_q) begin
                    if (out_hs) begin
                        x_d  = x_q >> SYM_WIDTH;
                        ov_d = 1'b0;
                    end
                end else if (need_word) begin
                    out_d = x_q[SYM_WIDTH-1:0];
                    ov_d  = 1'b1;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_busy && div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                x_d     = div_quo * STATE_WIDTH'(m_q) + STATE_WIDTH'(c_q) + STATE_WIDTH'(div_rem);
                state_d = ST_READY;
            end
            ST_FLUSH: begin
                if (ov_q) begin
                    if (out_hs) begin
                        x_d  = x_q >> SYM_WIDTH;
                        ov_d = 1'b0;
                        ol_d = 1'b0;
                        wc_d = wc_q - WC_W'(1);
                        if (wc_q == WC_W'(1)) begin
                            state_d = ST_INIT;
                        end
                    end
                end else begin
                    out_d = x_q[SYM_WIDTH-1:0];
                    ov_d  = 1'b1;
                    ol_d  = (wc_q == WC_W'(1));
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            x_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            f_q     <= '0;
            wc_q    <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= m_d;
            c_q     <= c_d;
            f_q     <= f_d;
            wc_q    <= wc_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_rdy   = ena && !bus.flush && (state_q == ST_READY);
    assign bus.out      = out_q;
    assign bus.out_vld  = ov_q && ena;
    assign bus.out_last = ol_q;
    assign err          = err_q;

endmodule
